// File: rtl/io_port_responder_pkg.sv
// io_port_responder_pkg: shared I/O window constants, register offsets and STATUS layout.
package io_port_responder_pkg;
  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;
  typedef enum logic [1:0] {
    OFF_DATA_IN  = 2'd0,
    OFF_DATA_OUT = 2'd1,
    OFF_STATUS   = 2'd2
  } io_off_e;
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_TX_OVF   = 4;
  function automatic logic [4:0] pack_status(input logic tx_ovf, rx_ovf, tx_full, tx_empty, rx_empty);
    logic [4:0] s;
    s = '0;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_TX_FULL]  = tx_full;
    s[ST_RX_OVF]   = rx_ovf;
    s[ST_TX_OVF]   = tx_ovf;
    return s;
  endfunction
endpackage

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: processor memory-bus access plus the external in/out word streams.
interface io_port_responder_if #(parameter int DATA_W = 16);
  logic [15:0]       input_addr;
  logic              input_mem_read;
  logic              input_mem_write;
  logic [DATA_W-1:0] input_mem_data;
  logic              output_hit;
  logic [DATA_W-1:0] output_rdata;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_valid;
  logic              ext_in_ready;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_valid;
  logic              ext_out_ready;
  modport master (
    output input_addr, input_mem_read, input_mem_write, input_mem_data,
    output ext_in_data, ext_in_valid, ext_out_ready,
    input  output_hit, output_rdata, ext_in_ready, ext_out_data, ext_out_valid
  );
  modport slave (
    input  input_addr, input_mem_read, input_mem_write, input_mem_data,
    input  ext_in_data, ext_in_valid, ext_out_ready,
    output output_hit, output_rdata, ext_in_ready, ext_out_data, ext_out_valid
  );
endinterface

// File: rtl/io_port_responder_fifo.sv
// io_port_responder_fifo: synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module io_port_responder_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: 3-word memory-mapped I/O window bridging the processor bus to
// buffered external in/out streams, with sticky overflow flags in STATUS.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          DATA_W     = 16
) (
  input logic               CLK,
  input logic               reset,
  io_port_responder_if.slave bus
);
  logic [15:0]       off;
  io_off_e           reg_sel;
  logic              rd, wr;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_ovf, tx_ovf, rx_set, tx_set, rx_clr, tx_clr;
  logic              tx_push;
  logic [DATA_W-1:0] rx_head, status, rdata_q, rdata_d;
  assign off            = bus.input_addr - IO_BASE;
  assign bus.output_hit = off < 16'd3;
  assign reg_sel        = io_off_e'(off[1:0]);
  assign rd             = bus.output_hit && bus.input_mem_read && !bus.input_mem_write;
  assign wr             = bus.output_hit && bus.input_mem_write && !bus.input_mem_read;
  assign tx_push        = wr && reg_sel == OFF_DATA_OUT;
  io_port_responder_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_rx (
    .clk   (CLK),
    .rst_n (reset),
    .push  (bus.ext_in_valid && !rx_full),
    .pop   (rd && reg_sel == OFF_DATA_IN),
    .din   (bus.ext_in_data),
    .head  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );
  io_port_responder_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_tx (
    .clk   (CLK),
    .rst_n (reset),
    .push  (tx_push),
    .pop   (bus.ext_out_ready),
    .din   (bus.input_mem_data),
    .head  (bus.ext_out_data),
    .empty (tx_empty),
    .full  (tx_full)
  );
  assign bus.ext_in_ready  = !rx_full;
  assign bus.ext_out_valid = !tx_empty;
  assign status = DATA_W'(pack_status(tx_ovf, rx_ovf, tx_full, tx_empty, rx_empty));
  assign rdata_d = !rd                     ? rdata_q :
                   reg_sel == OFF_DATA_IN  ? rx_head :
                   reg_sel == OFF_STATUS   ? status  : '0;
  // A full tx only drops the word when no external pop frees a slot that cycle.
  assign tx_set = tx_push && tx_full && !bus.ext_out_ready;
  assign rx_set = bus.ext_in_valid && rx_full;
  assign rx_clr = wr && reg_sel == OFF_STATUS && bus.input_mem_data[ST_RX_OVF];
  assign tx_clr = wr && reg_sel == OFF_STATUS && bus.input_mem_data[ST_TX_OVF];
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      rdata_q <= '0;
      rx_ovf  <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rx_ovf  <= rx_set || (rx_ovf && !rx_clr);
      tx_ovf  <= tx_set || (tx_ovf && !tx_clr);
    end
  assign bus.output_rdata = rdata_q;
endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_io_port_responder;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  io_port_responder_if #(.DATA_W(16)) bus ();
  io_port_responder dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;

  logic [15:0] rxq[$];
  logic [15:0] txq[$];
  logic        m_rx_ovf = 1'b0, m_tx_ovf = 1'b0;
  logic [15:0] m_rdata = 16'h0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {11'b0, m_tx_ovf, m_rx_ovf, txq.size() == 4, txq.size() == 0, rxq.size() == 0};
  endfunction

  // Compare process: outputs reflect state after the last rising edge; then advance the model.
  always @(negedge CLK) begin : cmp
    logic [15:0] o;
    logic mrd, mwr, rx_full, tx_pop, tx_push, rx_set, tx_set;
    o = bus.input_addr - 16'hFF00;
    chk("hit", 16'(bus.output_hit), 16'(o < 16'd3));
    if (!reset) begin
      rxq.delete();
      txq.delete();
      m_rx_ovf = 1'b0;
      m_tx_ovf = 1'b0;
      m_rdata = 16'h0;
    end
    chk("in_ready", 16'(bus.ext_in_ready), 16'(rxq.size() < 4));
    chk("out_valid", 16'(bus.ext_out_valid), 16'(txq.size() > 0));
    chk("out_data", bus.ext_out_data, txq.size() > 0 ? txq[0] : 16'h0);
    chk("rdata", bus.output_rdata, m_rdata);
    if (reset) begin
      mrd = o < 3 && bus.input_mem_read && !bus.input_mem_write;
      mwr = o < 3 && bus.input_mem_write && !bus.input_mem_read;
      rx_full = rxq.size() == 4;
      if (mrd) m_rdata = o == 0 ? (rxq.size() > 0 ? rxq[0] : 16'h0) : o == 2 ? m_status() : 16'h0;
      rx_set = bus.ext_in_valid && rx_full;
      tx_pop = bus.ext_out_ready && txq.size() > 0;
      tx_push = mwr && o == 1 && (txq.size() < 4 || tx_pop);
      tx_set = mwr && o == 1 && !tx_push;
      if (mrd && o == 0 && rxq.size() > 0) void'(rxq.pop_front());
      if (bus.ext_in_valid && !rx_full) rxq.push_back(bus.ext_in_data);
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) txq.push_back(bus.input_mem_data);
      m_rx_ovf = rx_set || (m_rx_ovf && !(mwr && o == 2 && bus.input_mem_data[3]));
      m_tx_ovf = tx_set || (m_tx_ovf && !(mwr && o == 2 && bus.input_mem_data[4]));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus.input_addr = a;
    bus.input_mem_data = d;
    bus.input_mem_write = 1'b1;
    cyc();
    bus.input_mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    bus.input_addr = a;
    bus.input_mem_read = 1'b1;
    cyc();
    bus.input_mem_read = 1'b0;
    d = bus.output_rdata;
  endtask

  logic [15:0] r;
  initial begin
    bus.input_addr = 16'h0;
    bus.input_mem_read = 1'b0;
    bus.input_mem_write = 1'b0;
    bus.input_mem_data = 16'h0;
    bus.ext_in_data = 16'h0;
    bus.ext_in_valid = 1'b1;
    bus.ext_out_ready = 1'b0;
    // Reset held with a valid input word pending
    repeat (3) cyc();
    chk("rst_ready", 16'(bus.ext_in_ready), 16'h1);
    chk("rst_valid", 16'(bus.ext_out_valid), 16'h0);
    bus.ext_in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    bus_read(16'hFF02, r);
    chk("rst_status", r, 16'h0003);
    // RX path
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data = 16'hA5A5;
    cyc();
    bus.ext_in_data = 16'h1234;
    cyc();
    bus.ext_in_valid = 1'b0;
    bus_read(16'hFF00, r);
    chk("rx_first", r, 16'hA5A5);
    bus_read(16'hFF00, r);
    chk("rx_second", r, 16'h1234);
    bus_read(16'hFF00, r);
    chk("rx_empty_read", r, 16'h0000);
    bus_read(16'hFF02, r);
    chk("rx_empty_bit", 16'(r[0]), 16'h1);
    // TX path: fifth write overflows; rx is empty so bit0 is also set
    for (int i = 1; i <= 5; i++) bus_write(16'hFF01, 16'(i));
    bus_read(16'hFF02, r);
    chk("tx_full_status", r, 16'h0015);
    bus.ext_out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("tx_drain", bus.ext_out_data, 16'(i));
      cyc();
    end
    chk("tx_drained", 16'(bus.ext_out_valid), 16'h0);
    bus.ext_out_ready = 1'b0;
    bus_write(16'hFF02, 16'h0010);
    // RX overflow and clear
    bus.ext_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ext_in_data = 16'h0010 + 16'(i);
      cyc();
    end
    bus.ext_in_valid = 1'b0;
    chk("rx_full_ready", 16'(bus.ext_in_ready), 16'h0);
    bus_read(16'hFF02, r);
    chk("rx_ovf_set", r, 16'h000A);
    bus_write(16'hFF02, 16'h0008);
    bus_read(16'hFF02, r);
    chk("rx_ovf_clr", r, 16'h0002);
    bus.ext_in_valid = 1'b1;
    cyc();
    bus.ext_in_valid = 1'b0;
    bus_read(16'hFF02, r);
    chk("rx_ovf_reset", r, 16'h000A);
    // Concurrency: full rx read with valid held pops only
    bus.ext_in_valid = 1'b1;
    bus_read(16'hFF00, r);
    bus.ext_in_valid = 1'b0;
    chk("rx_conc_data", r, 16'h0010);
    chk("rx_conc_ready", 16'(bus.ext_in_ready), 16'h1);
    bus_write(16'hFF01, 16'h0B01);
    bus_write(16'hFF01, 16'h0B02);
    bus.ext_out_ready = 1'b1;
    bus_write(16'hFF01, 16'h0B03);
    bus.ext_out_ready = 1'b0;
    chk("tx_conc_head", bus.ext_out_data, 16'h0B02);
    bus.ext_out_ready = 1'b1;
    cyc();
    chk("tx_conc_next", bus.ext_out_data, 16'h0B03);
    cyc();
    chk("tx_conc_empty", 16'(bus.ext_out_valid), 16'h0);
    bus.ext_out_ready = 1'b0;
    // Decode edges and mid-operation reset
    bus.input_addr = 16'hFEFF;
    #1 chk("hit_feff", 16'(bus.output_hit), 16'h0);
    bus.input_addr = 16'hFF03;
    #1 chk("hit_ff03", 16'(bus.output_hit), 16'h0);
    bus_write(16'hFEFF, 16'hFFFF);
    bus_write(16'hFF03, 16'hFFFF);
    for (int i = 0; i < 3; i++) bus_write(16'hFF01, 16'h0C00 + 16'(i));
    #2 reset = 1'b0;
    #1 chk("async_valid", 16'(bus.ext_out_valid), 16'h0);
    cyc();
    reset = 1'b1;
    cyc();
    bus_read(16'hFF02, r);
    chk("post_rst_status", r, 16'h0003);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      int rb;
      k = int'($urandom_range(0, 7));
      bus.input_addr = k == 3 ? 16'hFEFF : k == 4 ? 16'hFF03 :
                       k < 3 ? 16'hFF00 + 16'(k) : 16'hFF00 + 16'($urandom_range(0, 2));
      if (k == 7 && $urandom_range(0, 20) == 0) bus.input_addr = 16'($urandom);
      rb = (n / 500) % 3;
      bus.input_mem_read = $urandom_range(0, 2) == 0;
      bus.input_mem_write = $urandom_range(0, 2) == 0;
      bus.input_mem_data = 16'($urandom);
      bus.ext_in_data = 16'($urandom);
      bus.ext_in_valid = $urandom_range(0, 3) < 2 + (rb == 1 ? 1 : 0);
      bus.ext_out_ready = $urandom_range(0, 3) < (rb == 0 ? 1 : rb == 1 ? 3 : 2);
      reset = $urandom_range(0, 400) != 0;
      cyc();
    end
    reset = 1'b1;
    bus.input_mem_read = 1'b0;
    bus.input_mem_write = 1'b0;
    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
